// File: rtl/cpu_stackwb_pkg.sv
// rtl/cpu_stackwb_pkg.sv - shared push codes, type tags and FSM states for the stack write-back stage
package cpu_stackwb_pkg;

  localparam int ST_W = 35;

  localparam logic [2:0] UC_PUSHNONE = 3'd0;
  localparam logic [2:0] UC_PUSHALU  = 3'd1;
  localparam logic [2:0] UC_PUSHIMM  = 3'd2;
  localparam logic [2:0] UC_PUSHREG0 = 3'd3;
  localparam logic [2:0] UC_PUSHREG1 = 3'd4;

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_INT  = 3'd1;
  localparam logic [2:0] TYPE_PTR  = 3'd2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  // Codes 5..7 are undefined and behave like UC_PUSHNONE.
  function automatic logic is_push(input logic [2:0] code);
    return (code == UC_PUSHALU) || (code == UC_PUSHIMM) ||
           (code == UC_PUSHREG0) || (code == UC_PUSHREG1);
  endfunction

endpackage

// File: rtl/cpu_stackram.sv
// rtl/cpu_stackram.sv - DEPTH x 35 stack array, one synchronous write port, two asynchronous read ports
module cpu_stackram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [34:0]   wdata,
  input  logic [AW-1:0] raddr0,
  output logic [34:0]   rdata0,
  input  logic [AW-1:0] raddr1,
  output logic [34:0]   rdata1
);

  logic [34:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/cpu_stackwb.sv
// rtl/cpu_stackwb.sv - stage-5 operand stack write-back: pop then push, with sticky overflow/underflow fault
module cpu_stackwb
  import cpu_stackwb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_4a,
  input  logic [31:0]   pc_4a,
  input  logic [2:0]    c__to_push_4a,
  input  logic [34:0]   st__to_push_4a,
  input  logic [10:0]   st__to_pop_4a,
  output logic [34:0]   st__top0_5a,
  output logic [34:0]   st__top1_5a,
  output logic [AW:0]   st__depth_5a,
  output logic          retire_5a,
  output logic          fault_5a,
  output logic [31:0]   fault_pc_5a
);

  state_e      state_q, state_d;
  logic [AW:0] depth_q, depth_d;
  logic [34:0] top0_q, top0_d;
  logic [34:0] top1_q, top1_d;
  logic        retire_q, retire_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic [11:0]   depth_ext, pop_ext, after_pop, new_depth;
  logic          push, underflow, overflow, commit, ram_we;
  logic [AW-1:0] waddr, raddr0, raddr1;
  logic [34:0]   rdata0, rdata1;

  // 12-bit arithmetic keeps a pop of up to 2047 from wrapping against depth.
  always_comb begin
    depth_ext = 12'(depth_q);
    pop_ext   = {1'b0, st__to_pop_4a};
    push      = is_push(c__to_push_4a);
    underflow = pop_ext > depth_ext;
    after_pop = depth_ext - pop_ext;
    new_depth = after_pop + {11'd0, push};
    overflow  = !underflow && (new_depth > 12'(DEPTH));
    commit    = (state_q == ST_RUN) && valid_4a && !underflow && !overflow;
    ram_we    = commit && push && !rst;
    waddr     = AW'(after_pop);
    raddr0    = AW'(new_depth - 12'd1);
    raddr1    = AW'(new_depth - 12'd2);
  end

  cpu_stackram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (waddr),
    .wdata  (st__to_push_4a),
    .raddr0 (raddr0),
    .rdata0 (rdata0),
    .raddr1 (raddr1),
    .rdata1 (rdata1)
  );

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    top0_d     = top0_q;
    top1_d     = top1_q;
    retire_d   = 1'b0;
    fault_pc_d = fault_pc_q;
    case (state_q)
      ST_RUN: begin
        if (valid_4a) begin
          if (commit) begin
            depth_d  = new_depth[AW:0];
            retire_d = 1'b1;
            // Reads see the pre-write array; the pushed value bypasses into top0.
            if (push) begin
              top0_d = st__to_push_4a;
            end else begin
              top0_d = (new_depth >= 12'd1) ? rdata0 : 35'h0;
            end
            top1_d = (new_depth >= 12'd2) ? rdata1 : 35'h0;
          end else begin
            state_d    = ST_FAULT;
            fault_pc_d = pc_4a;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      depth_q    <= '0;
      top0_q     <= 35'h0;
      top1_q     <= 35'h0;
      retire_q   <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      top0_q     <= top0_d;
      top1_q     <= top1_d;
      retire_q   <= retire_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign st__top0_5a  = top0_q;
  assign st__top1_5a  = top1_q;
  assign st__depth_5a = depth_q;
  assign retire_5a    = retire_q;
  assign fault_5a     = (state_q == ST_FAULT);
  assign fault_pc_5a  = fault_pc_q;

endmodule

// File: tb/tb_cpu_stackwb.sv
// tb/tb_cpu_stackwb.sv - self-checking bench for cpu_stackwb: vector table, directed corners, random vs queue model
module tb_cpu_stackwb;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_4a = 1'b0;
  logic [31:0] pc_4a = 32'h0;
  logic [2:0]  c__to_push_4a = 3'd0;
  logic [34:0] st__to_push_4a = 35'h0;
  logic [10:0] st__to_pop_4a = 11'd0;
  logic [34:0] st__top0_5a, st__top1_5a;
  logic [AW:0] st__depth_5a;
  logic        retire_5a, fault_5a;
  logic [31:0] fault_pc_5a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_stackwb #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_4a       (valid_4a),
    .pc_4a          (pc_4a),
    .c__to_push_4a  (c__to_push_4a),
    .st__to_push_4a (st__to_push_4a),
    .st__to_pop_4a  (st__to_pop_4a),
    .st__top0_5a    (st__top0_5a),
    .st__top1_5a    (st__top1_5a),
    .st__depth_5a   (st__depth_5a),
    .retire_5a      (retire_5a),
    .fault_5a       (fault_5a),
    .fault_pc_5a    (fault_pc_5a)
  );

  // Reference model: the stack as a queue, back = top of stack.
  logic [34:0] m_stack[$];
  logic        m_fault, m_retire;
  logic [31:0] m_fpc;
  logic [34:0] m_top0, m_top1;

  task automatic model_step(input logic r, input logic v, input logic [2:0] code,
                            input logic [34:0] val, input int pop, input logic [31:0] pc);
    int push;
    m_retire = 1'b0;
    if (r) begin
      m_stack.delete();
      m_fault = 1'b0;
      m_fpc   = 32'h0;
      m_top0  = 35'h0;
      m_top1  = 35'h0;
    end else if (v && !m_fault) begin
      push = (code >= 3'd1 && code <= 3'd4) ? 1 : 0;
      if (pop > m_stack.size() || m_stack.size() - pop + push > DEPTH) begin
        m_fault = 1'b1;
        m_fpc   = pc;
      end else begin
        for (int i = 0; i < pop; i++) void'(m_stack.pop_back());
        if (push == 1) m_stack.push_back(val);
        m_retire = 1'b1;
        m_top0 = (m_stack.size() >= 1) ? m_stack[m_stack.size()-1] : 35'h0;
        m_top1 = (m_stack.size() >= 2) ? m_stack[m_stack.size()-2] : 35'h0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] code,
                       input logic [34:0] val, input logic [10:0] pop, input logic [31:0] pc);
    rst = r; valid_4a = v; c__to_push_4a = code; st__to_push_4a = val;
    st__to_pop_4a = pop; pc_4a = pc;
    model_step(r, v, code, val, int'(pop), pc);
    @(posedge clk);
    #1;
    rst = 1'b0; valid_4a = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".depth"},  64'(st__depth_5a), 64'(m_stack.size()));
    chk({tag, ".top0"},   64'(st__top0_5a),  64'(m_top0));
    chk({tag, ".top1"},   64'(st__top1_5a),  64'(m_top1));
    chk({tag, ".retire"}, 64'(retire_5a),    64'(m_retire));
    chk({tag, ".fault"},  64'(fault_5a),     64'(m_fault));
    chk({tag, ".fpc"},    64'(fault_pc_5a),  64'(m_fpc));
  endtask

  typedef struct {
    logic        r, v;
    logic [2:0]  code;
    logic [34:0] val;
    logic [10:0] pop;
    logic [31:0] pc;
    logic [8:0]  e_depth;
    logic [34:0] e_top0, e_top1;
    logic        e_retire, e_fault;
    logic [31:0] e_fpc;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic [2:0] code, logic [34:0] val,
                              logic [10:0] pop, logic [31:0] pc, logic [8:0] ed,
                              logic [34:0] e0, logic [34:0] e1, logic er, logic ef,
                              logic [31:0] efpc);
    vec_t t;
    t.r = r; t.v = v; t.code = code; t.val = val; t.pop = pop; t.pc = pc;
    t.e_depth = ed; t.e_top0 = e0; t.e_top1 = e1; t.e_retire = er; t.e_fault = ef;
    t.e_fpc = efpc;
    return t;
  endfunction

  localparam logic [34:0] P = 35'h1_0000_0005;
  localparam logic [34:0] A = 35'h0_0000_00AA;
  localparam logic [34:0] B = 35'h2_0000_00BB;
  localparam logic [34:0] C = 35'h3_0000_00CC;
  localparam logic [34:0] D = 35'h4_0000_00DD;
  localparam logic [34:0] E = 35'h5_0000_00EE;

  vec_t tbl[15];

  initial begin
    tbl[0]  = mk(1, 0, 3'd0, 35'h0, 11'd0, 32'h100, 9'd0, 35'h0, 35'h0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 3'd2, P,     11'd0, 32'h104, 9'd1, P,     35'h0, 1, 0, 32'h0);
    tbl[2]  = mk(1, 0, 3'd0, 35'h0, 11'd0, 32'h108, 9'd0, 35'h0, 35'h0, 0, 0, 32'h0);
    tbl[3]  = mk(0, 1, 3'd2, A,     11'd0, 32'h10c, 9'd1, A,     35'h0, 1, 0, 32'h0);
    tbl[4]  = mk(0, 1, 3'd3, B,     11'd0, 32'h110, 9'd2, B,     A,     1, 0, 32'h0);
    tbl[5]  = mk(0, 1, 3'd4, C,     11'd0, 32'h114, 9'd3, C,     B,     1, 0, 32'h0);
    tbl[6]  = mk(0, 1, 3'd1, D,     11'd2, 32'h118, 9'd2, D,     A,     1, 0, 32'h0);
    tbl[7]  = mk(0, 0, 3'd3, E,     11'd5, 32'h11c, 9'd2, D,     A,     0, 0, 32'h0);
    tbl[8]  = mk(0, 1, 3'd0, E,     11'd0, 32'h120, 9'd2, D,     A,     1, 0, 32'h0);
    tbl[9]  = mk(0, 1, 3'd0, E,     11'd1, 32'h124, 9'd1, A,     35'h0, 1, 0, 32'h0);
    tbl[10] = mk(0, 1, 3'd6, 35'bx, 11'd0, 32'h128, 9'd1, A,     35'h0, 1, 0, 32'h0);
    tbl[11] = mk(0, 1, 3'd2, E,     11'd1, 32'h12c, 9'd1, E,     35'h0, 1, 0, 32'h0);
    tbl[12] = mk(0, 1, 3'd0, 35'h0, 11'd2, 32'h40,  9'd1, E,     35'h0, 0, 1, 32'h40);
    tbl[13] = mk(0, 1, 3'd2, D,     11'd0, 32'h134, 9'd1, E,     35'h0, 0, 1, 32'h40);
    tbl[14] = mk(1, 1, 3'd2, D,     11'd0, 32'h138, 9'd0, 35'h0, 35'h0, 0, 0, 32'h0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].code, tbl[i].val, tbl[i].pop, tbl[i].pc);
      chk($sformatf("vec%0d.depth", i),  64'(st__depth_5a), 64'(tbl[i].e_depth));
      chk($sformatf("vec%0d.top0", i),   64'(st__top0_5a),  64'(tbl[i].e_top0));
      chk($sformatf("vec%0d.top1", i),   64'(st__top1_5a),  64'(tbl[i].e_top1));
      chk($sformatf("vec%0d.retire", i), 64'(retire_5a),    64'(tbl[i].e_retire));
      chk($sformatf("vec%0d.fault", i),  64'(fault_5a),     64'(tbl[i].e_fault));
      chk($sformatf("vec%0d.fpc", i),    64'(fault_pc_5a),  64'(tbl[i].e_fpc));
    end

    // Fill to DEPTH, then one push too many.
    drive(1, 0, 3'd0, 35'h0, 11'd0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 3'd1 + 3'(i % 4), {3'(i), 32'($urandom)}, 11'd0, 32'h1000 + 32'(i));
      check_model($sformatf("fill%0d", i));
    end
    chk("full.depth", 64'(st__depth_5a), 64'd256);
    chk("full.fault", 64'(fault_5a), 64'd0);
    drive(0, 1, 3'd2, 35'h7_1234_5678, 11'd0, 32'h0000_2000);
    chk("ovf.fault", 64'(fault_5a), 64'd1);
    chk("ovf.depth", 64'(st__depth_5a), 64'd256);
    chk("ovf.fpc", 64'(fault_pc_5a), 64'h2000);
    chk("ovf.retire", 64'(retire_5a), 64'd0);
    check_model("ovf");

    // Reset wins over a same-cycle push at depth 3.
    drive(1, 0, 3'd0, 35'h0, 11'd0, 32'h0);
    for (int i = 0; i < 3; i++) drive(0, 1, 3'd2, 35'(i + 1), 11'd0, 32'h0);
    chk("pre_rst.depth", 64'(st__depth_5a), 64'd3);
    drive(1, 1, 3'd2, 35'h9, 11'd0, 32'h0);
    chk("rst_push.depth", 64'(st__depth_5a), 64'd0);
    chk("rst_push.retire", 64'(retire_5a), 64'd0);
    chk("rst_push.fault", 64'(fault_5a), 64'd0);
    check_model("rst_push");

    // Underflow with a huge pop must not wrap.
    drive(0, 1, 3'd0, 35'h0, 11'd2047, 32'h0000_3000);
    chk("bigpop.fault", 64'(fault_5a), 64'd1);
    check_model("bigpop");

    drive(1, 0, 3'd0, 35'h0, 11'd0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic r, v;
      logic [2:0] code;
      logic [10:0] pop;
      int k;
      k = $urandom_range(0, 99);
      pop = (k < 50) ? 11'd0 : (k < 80) ? 11'd1 : (k < 97) ? 11'd2 : 11'($urandom_range(0, 2047));
      v = ($urandom_range(0, 9) < 8);
      code = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 299) == 0) || (m_fault && $urandom_range(0, 7) == 0);
      drive(r, v, code, {3'($urandom), 32'($urandom)}, pop, 32'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
